// File: rtl/ifft8_seq_if.sv
// ifft8_seq_if
// Groups the two sample streams of the sequential 8-point inverse FFT.
//
// Handshake rule for both streams: a sample moves on a rising clock edge
// exactly when valid and ready are both high on that edge. The source holds
// valid and its data stable until that edge. Ready may be asserted without
// valid, and it has no effect while valid is low.
//
// Signals:
//   in_valid / in_ready      frequency-domain input stream, X[0..7] in order
//   in_re / in_im            32-bit signed real/imag of X[k]
//   out_valid / out_ready    time-domain output stream, x[0..7] in order
//   out_re / out_im          32-bit signed real/imag of x[n]
//   out_last                 high together with x[7]
// Modports:
//   slave   the transform block (consumes input, produces output)
//   master  the environment around it
interface ifft8_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_re;
    logic [31:0] in_im;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_re;
    logic [31:0] out_im;
    logic        out_last;

    modport slave (
        input  in_valid, in_re, in_im, out_ready,
        output in_ready, out_valid, out_re, out_im, out_last
    );

    modport master (
        output in_valid, in_re, in_im, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_last
    );
endinterface

// File: rtl/ifft8_seq.sv
// ifft8_seq
// Sequential 8-point inverse FFT. The block loads one frame of 8 complex
// samples into a register file in bit-reversed order. It then runs 12
// radix-2 DIT butterflies through a single datapath, using W = e^{+j*2*pi/8}.
// Finally it streams the 8 results out in natural order, each scaled by 1/8
// with an arithmetic shift.
//
// Ports:
//   clk          rising-edge system clock
//   rst_n        asynchronous active-low reset
//   bus          ifft8_seq_if.slave: input and output sample streams
//   o_dbg_state  current FSM state (0 LOAD, 1 CALC, 2 UNLOAD)
module ifft8_seq (
    input  logic        clk,
    input  logic        rst_n,
    ifft8_seq_if.slave  bus,
    output logic [1:0]  o_dbg_state
);
    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_CALC   = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    // cos(pi/4) in Q15
    localparam logic signed [48:0] C_TW = 49'sd23170;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [2:0]         r_cnt;      // sample index during LOAD and UNLOAD
    logic [3:0]         r_bfly;     // {stage, butterfly} during CALC
    logic signed [31:0] r_re [8];
    logic signed [31:0] r_im [8];

    logic w_in_fire;
    logic w_out_fire;
    assign w_in_fire  = bus.in_valid  && (r_state == ST_LOAD);
    assign w_out_fire = bus.out_ready && (r_state == ST_UNLOAD);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_LOAD;
            r_cnt   <= 3'd0;
            r_bfly  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            // Wraps 7 -> 0, so each phase starts from index 0.
            if (w_in_fire || w_out_fire)
                r_cnt <= r_cnt + 3'd1;
            if (r_state == ST_CALC)
                r_bfly <= (r_bfly == 4'd11) ? 4'd0 : r_bfly + 4'd1;
        end
    end

    logic signed [31:0] w_o_re;
    logic signed [31:0] w_o_im;
    assign w_o_re = r_re[r_cnt] >>> 3;
    assign w_o_im = r_im[r_cnt] >>> 3;

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_re    = '0;
        bus.out_im    = '0;
        case (r_state)
            ST_LOAD: begin
                bus.in_ready = 1'b1;
                if (w_in_fire && (r_cnt == 3'd7))
                    w_state_nxt = ST_CALC;
            end
            ST_CALC: begin
                if (r_bfly == 4'd11)
                    w_state_nxt = ST_UNLOAD;
            end
            ST_UNLOAD: begin
                bus.out_valid = 1'b1;
                bus.out_last  = (r_cnt == 3'd7);
                bus.out_re    = w_o_re;
                bus.out_im    = w_o_im;
                if (w_out_fire && (r_cnt == 3'd7))
                    w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_LOAD;
        endcase
    end

    assign o_dbg_state = r_state;

    // ---------------- butterfly addressing ----------------
    // stage s uses half-span h = 2^s: top = (j/h)*2h + j%h, bot = top + h,
    // twiddle exponent k = (j%h)*(4/h).
    logic [1:0] w_stage;
    logic [1:0] w_j;
    logic [2:0] w_top;
    logic [2:0] w_bot;
    logic [1:0] w_k;
    assign w_stage = r_bfly[3:2];
    assign w_j     = r_bfly[1:0];

    always_comb begin
        w_top = 3'd0;
        w_bot = 3'd0;
        w_k   = 2'd0;
        case (w_stage)
            2'd0: begin
                w_top = {w_j, 1'b0};
                w_bot = {w_j, 1'b1};
                w_k   = 2'd0;
            end
            2'd1: begin
                w_top = {w_j[1], 1'b0, w_j[0]};
                w_bot = {w_j[1], 1'b1, w_j[0]};
                w_k   = {w_j[0], 1'b0};
            end
            default: begin
                w_top = {1'b0, w_j};
                w_bot = {1'b1, w_j};
                w_k   = w_j;
            end
        endcase
    end

    // ---------------- twiddle product ----------------
    logic signed [31:0] w_a_re, w_a_im, w_b_re, w_b_im;
    assign w_a_re = r_re[w_top];
    assign w_a_im = r_im[w_top];
    assign w_b_re = r_re[w_bot];
    assign w_b_im = r_im[w_bot];

    // 33-bit pre-sums so Bre +/- Bim cannot overflow before the multiply.
    logic [32:0] w_sum, w_dif, w_nsum;
    assign w_sum  = {w_b_re[31], w_b_re} + {w_b_im[31], w_b_im};
    assign w_dif  = {w_b_re[31], w_b_re} - {w_b_im[31], w_b_im};
    assign w_nsum = 33'd0 - w_sum;

    // k=1: ((Bre-Bim)C, (Bre+Bim)C); k=3: ((-Bre-Bim)C, (Bre-Bim)C).
    logic [32:0]        w_mre_in, w_mim_in;
    logic signed [48:0] w_mre, w_mim;
    assign w_mre_in = (w_k == 2'd1) ? w_dif : w_nsum;
    assign w_mim_in = (w_k == 2'd1) ? w_sum : w_dif;
    assign w_mre    = $signed({{16{w_mre_in[32]}}, w_mre_in}) * C_TW;
    assign w_mim    = $signed({{16{w_mim_in[32]}}, w_mim_in}) * C_TW;

    // Bits [46:15] are the product arithmetically shifted right by 15 and
    // truncated to 32 bits; the remaining bits are discarded on purpose.
    logic w_unused_prod;
    assign w_unused_prod = ^{w_mre[48:47], w_mre[14:0], w_mim[48:47], w_mim[14:0]};

    logic signed [31:0] w_t_re, w_t_im;
    always_comb begin
        w_t_re = w_b_re;
        w_t_im = w_b_im;
        case (w_k)
            2'd1, 2'd3: begin
                w_t_re = w_mre[46:15];
                w_t_im = w_mim[46:15];
            end
            2'd2: begin
                w_t_re = -w_b_im;
                w_t_im = w_b_re;
            end
            default: begin
                w_t_re = w_b_re;
                w_t_im = w_b_im;
            end
        endcase
    end

    // 32-bit wrapping butterfly outputs
    logic signed [31:0] w_s_re, w_s_im, w_d_re, w_d_im;
    assign w_s_re = w_a_re + w_t_re;
    assign w_s_im = w_a_im + w_t_im;
    assign w_d_re = w_a_re - w_t_re;
    assign w_d_im = w_a_im - w_t_im;

    // ---------------- register file ----------------
    logic [2:0] w_ld_addr;
    assign w_ld_addr = {r_cnt[0], r_cnt[1], r_cnt[2]};   // bit-reversed index

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                r_re[i] <= '0;
                r_im[i] <= '0;
            end
        end else if (w_in_fire) begin
            r_re[w_ld_addr] <= bus.in_re;
            r_im[w_ld_addr] <= bus.in_im;
        end else if (r_state == ST_CALC) begin
            r_re[w_top] <= w_s_re;
            r_im[w_top] <= w_s_im;
            r_re[w_bot] <= w_d_re;
            r_im[w_bot] <= w_d_im;
        end
    end
endmodule

// File: tb/tb_ifft8_seq.sv
// tb_ifft8_seq
// Directed bench for ifft8_seq. Each entry in the expected queue packs
// {out_last, out_re, out_im} for one output sample.
module tb_ifft8_seq;
    localparam int W = 65;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    ifft8_seq_if bus();

    ifft8_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [31:0]  f_re [8];
    logic [31:0]  f_im [8];
    time          t_acc;
    time          t_first;

    int sb_re [8] = '{1000, 707, 0, -708, -1000, -707, 0, 707};
    int sb_im [8] = '{0, 707, 1000, 707, 0, -707, -1000, -707};

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        check(tag, {64'b0, obs}, {64'b0, exp});
    endtask

    task automatic push_exp(input logic [31:0] re, input logic [31:0] im, input logic last);
        exp_q.push_back({last, re, im});
    endtask

    // ---------------- frame builders ----------------
    task automatic clear_frame();
        for (int k = 0; k < 8; k++) begin
            f_re[k] = 32'd0;
            f_im[k] = 32'd0;
        end
    endtask

    task automatic load_impulse();
        clear_frame();
        f_re[0] = 32'd8000;
        for (int n = 0; n < 8; n++) push_exp(32'd1000, 32'd0, n == 7);
    endtask

    task automatic load_bin1();
        clear_frame();
        f_re[1] = 32'd8000;
        for (int n = 0; n < 8; n++) push_exp(sb_re[n], sb_im[n], n == 7);
    endtask

    task automatic load_wrap();
        for (int k = 0; k < 8; k++) begin
            f_re[k] = 32'h7FFF_FFFF;
            f_im[k] = 32'd0;
        end
        push_exp(32'hFFFF_FFFF, 32'd0, 1'b0);
        for (int n = 1; n < 8; n++) push_exp(32'd0, 32'd0, n == 7);
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge; returns at the falling edge after the 8th
    // accept, with t_acc holding the time of that accept edge.
    task automatic send_frame(input bit gap, input bit hold);
        int guard;
        for (int k = 0; k < 8; k++) begin
            bus.in_valid = 1'b1;
            bus.in_re    = f_re[k];
            bus.in_im    = f_im[k];
            guard = 0;
            while (!bus.in_ready && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            if (!bus.in_ready) begin
                check_bit("in_ready_timeout", bus.in_ready, 1'b1);
                return;
            end
            @(posedge clk);
            t_acc = $time;
            @(negedge clk);
            if (gap && k < 7) begin
                bus.in_valid = 1'b0;
                bus.in_re    = 32'hDEAD_BEEF;
                @(negedge clk);
            end
        end
        bus.in_valid = hold;
        bus.in_re    = 32'h1234_5678;
        bus.in_im    = 32'h9ABC_DEF0;
    endtask

    // Collects one output frame. stall_at < 0 means no backpressure.
    task automatic recv_frame(input bit chk_lat, input int stall_at);
        int           guard;
        logic [W-1:0] e;
        for (int n = 0; n < 8; n++) begin
            guard = 0;
            while (!bus.out_valid && guard < 100) begin
                check_bit("in_ready_busy", bus.in_ready, 1'b0);
                @(negedge clk);
                guard++;
            end
            if (!bus.out_valid) begin
                check_bit("out_valid_timeout", bus.out_valid, 1'b1);
                return;
            end
            if (n == 0 && chk_lat) begin
                t_first = $time;
                check("latency", 65'((t_first - t_acc - 5) / 10), 65'd12);
            end
            check_bit("in_ready_busy", bus.in_ready, 1'b0);
            e = exp_q.pop_front();
            check($sformatf("out_sample_%0d", n), {bus.out_last, bus.out_re, bus.out_im}, e);
            if (n == stall_at) begin
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_hold", {bus.out_last, bus.out_re, bus.out_im}, e);
                    check_bit("stall_valid", bus.out_valid, 1'b1);
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
        end
        check("ready_after_unload", {63'b0, bus.in_ready, bus.out_valid}, 65'b10);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        time t_first_acc;
        bus.in_valid  = 1'b0;
        bus.in_re     = 32'd0;
        bus.in_im     = 32'd0;
        bus.out_ready = 1'b1;

        // reset values
        repeat (3) @(negedge clk);
        check_bit("rst_in_ready", bus.in_ready, 1'b1);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check_bit("rst_out_last", bus.out_last, 1'b0);
        check("rst_out_data", {1'b0, bus.out_re, bus.out_im}, 65'd0);
        check("rst_state", {63'b0, dbg_state}, 65'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("post_rst_in_ready", bus.in_ready, 1'b1);

        // impulse
        load_impulse();
        send_frame(1'b0, 1'b0);
        recv_frame(1'b1, -1);

        // single bin
        load_bin1();
        send_frame(1'b0, 1'b0);
        recv_frame(1'b1, -1);

        // gapped input with a 3-cycle output stall at n=2
        load_bin1();
        send_frame(1'b1, 1'b0);
        recv_frame(1'b1, 2);

        // reset in the middle of CALC; the partial result must vanish
        clear_frame();
        f_re[1] = 32'd8000;
        send_frame(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_bit("midrst_in_ready", bus.in_ready, 1'b1);
        check_bit("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_state", {63'b0, dbg_state}, 65'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_impulse();
        send_frame(1'b0, 1'b0);
        recv_frame(1'b1, -1);

        // back-to-back frames with in_valid and out_ready held high
        load_impulse();
        send_frame(1'b0, 1'b1);
        t_first_acc = t_acc;
        recv_frame(1'b1, -1);
        load_bin1();
        send_frame(1'b0, 1'b1);
        check("cadence", 65'((t_acc - t_first_acc) / 10), 65'd28);
        recv_frame(1'b1, -1);
        bus.in_valid = 1'b0;

        // wrap-around accumulation
        load_wrap();
        send_frame(1'b0, 1'b0);
        recv_frame(1'b1, -1);

        check("queue_empty", 65'(exp_q.size()), 65'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a wait slips past its own bound.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ifft8_seq.md
# ifft8_seq

Sequential 8-point inverse FFT that reverses the transform performed by the combinational FFT stage chain. It accepts one frequency-domain frame of 8 complex 32-bit samples over a valid/ready stream and computes the inverse transform with a single reused radix-2 DIT butterfly. It then streams 8 time-domain complex samples out, scaled by 1/8. It sits downstream of the FFT path and reconstructs the original sample sequence.

## Interface
- No parameters; N=8, data width 32, twiddle constant C=23170 (cos(pi/4) in Q15) are fixed.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample X[k] present.
- in_ready  out  1  block can accept an input sample.
- in_re, in_im  in  32 each  signed two's-complement real/imag of X[k], natural order k=0..7.
- out_valid  out  1  output sample x[n] present.
- out_ready  in  1  downstream accepts output.
- out_re, out_im  out  32 each  signed real/imag of x[n], natural order n=0..7.
- out_last  out  1  high with n=7.

## Operation
- States: LOAD, CALC, UNLOAD. Reset enters LOAD, with sample counter 0 and butterfly counter 0.
- Reset values: in_ready=1, out_valid=0, out_last=0, out_re=0, out_im=0. The internal 8x(32+32) register file is cleared to 0.
- LOAD: in_ready=1. On each in_valid&&in_ready the sample is written to register address bitrev3(count), i.e. k=0,1,2..7 go to addresses 0,4,2,6,1,5,3,7. After the 8th accept, go to CALC and set in_ready=0.
- CALC: one butterfly per cycle, 12 total. For stage s=0..2 and butterfly j=0..3:
  - h=2^s.
  - top=(j/h)*2h+(j%h), bot=top+h.
  - twiddle exponent k=(j%h)*(4/h).
- Twiddle product T = W^k * B, where W=e^{+j*2*pi/8} and B is the value at address bot:
  - k=0: T=B.
  - k=1: T=((Bre-Bim)*C>>>15, (Bre+Bim)*C>>>15).
  - k=2: T=(-Bim, Bre).
  - k=3: T=((-Bre-Bim)*C>>>15, (Bre-Bim)*C>>>15).
- Butterfly update: reg[top]=A+T and reg[bot]=A-T, both written on the same edge.
- Arithmetic width rules:
  - Add/sub is 32-bit two's complement and wraps on overflow, with no saturation.
  - Twiddle pre-sums are computed at 33 bits. The product is computed at 49 bits, arithmetically shifted right by 15 (floor), then truncated to 32 bits.
- After the 12th butterfly, go to UNLOAD.
- UNLOAD: drive out_re/out_im = reg[n]>>>3 (arithmetic, floor) for n=0..7, with out_valid=1.
  - n advances only on out_valid&&out_ready.
  - out_last=1 while n=7.
  - After the 7th-index handshake, go to LOAD: out_valid=0, in_ready=1.
- Inputs presented while in_ready=0 are ignored. out_ready is ignored while out_valid=0.

## Timing
- Input: at most one sample per cycle. Minimum 8 cycles per frame load.
- Latency: the 8th input accept edge is E0. Butterflies execute on E1..E12. out_valid rises after E12, so the first output is visible 12 cycles after the last input accept.
- Output: one sample per cycle when out_ready is held high, so 8 cycles minimum.
- Back-to-back frame cadence is 28 cycles minimum (8 load + 12 calc + 8 unload).
- Backpressure: while out_valid=1 and out_ready=0, out_re/out_im/out_last hold stable.
- in_ready goes high in the cycle after the final output handshake. There is no overlap of LOAD with UNLOAD.
- Reset asserted in any state clears everything immediately, as asynchronous reset. A partial frame is discarded and no output is produced for it.

## Test plan
- Impulse: X[0]=(8000,0), X[1..7]=0 -> all 8 outputs (1000,0), out_last only on the 8th.
- Single bin: X[1]=(8000,0), others 0 -> outputs in order (1000,0), (707,707), (0,1000), (-708,707), (-1000,0), (-707,-707), (0,-1000), (707,-707).
- Backpressure and gapped input:
  - Stimulus: in_valid toggled every other cycle during load, and out_ready low for 3 cycles at n=2 using the single-bin frame.
  - Required: values and order are unchanged, n=2 output is held stable through the stall, and first out_valid appears exactly 12 cycles after the 8th accept.
- Reset mid-CALC:
  - Stimulus: deassert rst_n 5 cycles into CALC, then load the impulse frame.
  - Required: in_ready=1 and out_valid=0 immediately on reset, and the next output frame is the impulse result only.
- Back-to-back frames:
  - Stimulus: impulse frame, then single-bin frame, with in_valid and out_ready held high.
  - Required: both frames are correct, in_ready is low from the 8th accept through the final output handshake, and the cadence is 28 cycles.
- Wrap: X[0..7] all (0x7FFFFFFF,0).
  - X[0]: 8*0x7FFFFFFF mod 2^32 = 0xFFFFFFF8, so x[0] = (0xFFFFFFF8>>>3, 0) = (-1,0).
  - x[1..7]: (0,0).
  - No X or Z values appear on any output.
